multiplicador_seq: RTL and testbench

- Sequential 16x16 unsigned shift-add multiplier controller.
- Sequences one shared instance of the team's 16-bit `Adder` (17-bit `Soma`) over 16 iterations to form a 32-bit product.
- Sits under `Multiplicador/` and sits between the CPU's MULT request logic and the adder datapath.
- Start/done handshake toward the CPU.

---
 rtl/multiplicador_seq_pkg.sv | 25 ++
 rtl/multiplicador_seq_adder.sv | 24 ++
 rtl/multiplicador_seq.sv | 146 ++++++++++++++
 tb/tb_multiplicador_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_seq_pkg.sv
// -----------------------------------------------------------------------------
// multiplicador_seq_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - LARGURA_PADRAO : default operand width (must match the Adder width)
//   - CONT_PADRAO    : default iteration counter width
//   - estado_t       : controller state encoding (2'd3 is illegal)
//   - ultima_iter()  : counter value that marks the final iteration
// -----------------------------------------------------------------------------
package multiplicador_seq_pkg;

    localparam int LARGURA_PADRAO = 16;
    localparam int CONT_PADRAO    = 5;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CALCULA   = 2'd1,
        CONCLUIDO = 2'd2
    } estado_t;

    // Counter value present during the last of the LARGURA iterations.
    function automatic logic [CONT_PADRAO-1:0] ultima_iter(input int largura);
        ultima_iter = CONT_PADRAO'(largura - 1);
    endfunction

endpackage

// File: rtl/multiplicador_seq_adder.sv
// -----------------------------------------------------------------------------
// Adder
// Combinational unsigned adder shared by the multiplier datapath.
// Ports:
//   OperandoA [LARGURA-1:0] : first addend
//   OperandoB [LARGURA-1:0] : second addend
//   Soma      [LARGURA:0]   : full sum including carry-out in the MSB
// -----------------------------------------------------------------------------
module Adder
    import multiplicador_seq_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic [LARGURA-1:0] OperandoA,
    input  logic [LARGURA-1:0] OperandoB,
    output logic [LARGURA:0]   Soma
);

    // Zero-extend both operands so the carry lands in Soma[LARGURA].
    always_comb begin
        Soma = {1'b0, OperandoA} + {1'b0, OperandoB};
    end

endmodule

// File: rtl/multiplicador_seq.sv
// -----------------------------------------------------------------------------
// multiplicador_seq
// 16x16 unsigned shift-add multiplier controller. One shared Adder is stepped
// through LARGURA iterations to form a 2*LARGURA-bit product in {A,Q}.
// Ports:
//   Clk           : clock, rising edge
//   Rst_n         : asynchronous active-low reset, clears all state
//   Iniciar       : start request, only honoured in OCIOSO
//   Multiplicando : operand M, captured on accepted start
//   Multiplicador : operand Q, captured on accepted start
//   Ocupado       : registered, high while in CALCULA
//   Pronto        : registered, one-cycle pulse in CONCLUIDO
//   Produto       : {A,Q}, stable from CONCLUIDO until the next accepted start
// -----------------------------------------------------------------------------
module multiplicador_seq
    import multiplicador_seq_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int CONT_W  = CONT_PADRAO
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Iniciar,
    input  logic [LARGURA-1:0]     Multiplicando,
    input  logic [LARGURA-1:0]     Multiplicador,
    output logic                   Ocupado,
    output logic                   Pronto,
    output logic [2*LARGURA-1:0]   Produto
);

    localparam logic [CONT_W-1:0] ULTIMA = CONT_W'(LARGURA - 1);

    estado_t               estado_q,   estado_d;
    logic [LARGURA-1:0]    a_q,        a_d;
    logic [LARGURA-1:0]    q_q,        q_d;
    logic [LARGURA-1:0]    m_q,        m_d;
    logic [CONT_W-1:0]     contador_q, contador_d;
    logic                  ocupado_q,  ocupado_d;
    logic                  pronto_q,   pronto_d;

    logic [LARGURA-1:0]    operando_b_s;
    logic [LARGURA:0]      soma_s;

    // Add M only when the current multiplier LSB is set.
    always_comb begin
        if (q_q[0]) begin
            operando_b_s = m_q;
        end else begin
            operando_b_s = {LARGURA{1'b0}};
        end
    end

    Adder #(
        .LARGURA (LARGURA)
    ) u_adder (
        .OperandoA (a_q),
        .OperandoB (operando_b_s),
        .Soma      (soma_s)
    );

    // State register, datapath registers and registered status outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            estado_q   <= OCIOSO;
            a_q        <= {LARGURA{1'b0}};
            q_q        <= {LARGURA{1'b0}};
            m_q        <= {LARGURA{1'b0}};
            contador_q <= {CONT_W{1'b0}};
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            contador_q <= contador_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    // Next-state logic; the unused encoding falls back to OCIOSO.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (Iniciar) begin
                    estado_d = CALCULA;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            CALCULA: begin
                if (contador_q == ULTIMA) begin
                    estado_d = CONCLUIDO;
                end else begin
                    estado_d = CALCULA;
                end
            end
            CONCLUIDO: estado_d = OCIOSO;
            default:   estado_d = OCIOSO;
        endcase
    end

    // Datapath next values: load on accepted start, shift-add in CALCULA.
    // The adder carry shifts into A's MSB and the sum LSB into Q's MSB, so
    // nothing is lost even for FFFF x FFFF.
    always_comb begin
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        contador_d = contador_q;
        case (estado_q)
            OCIOSO: begin
                if (Iniciar) begin
                    m_d        = Multiplicando;
                    q_d        = Multiplicador;
                    a_d        = {LARGURA{1'b0}};
                    contador_d = {CONT_W{1'b0}};
                end else begin
                    contador_d = contador_q;
                end
            end
            CALCULA: begin
                a_d        = soma_s[LARGURA:1];
                q_d        = {soma_s[0], q_q[LARGURA-1:1]};
                contador_d = contador_q + {{(CONT_W-1){1'b0}}, 1'b1};
            end
            default: begin
                contador_d = contador_q;
            end
        endcase
    end

    // Status outputs decoded from the next state so the flops line up
    // with the state register.
    always_comb begin
        ocupado_d = (estado_d == CALCULA);
        pronto_d  = (estado_d == CONCLUIDO);
    end

    assign Ocupado = ocupado_q;
    assign Pronto  = pronto_q;
    assign Produto = {a_q, q_q};

endmodule

// File: tb/tb_multiplicador_seq.sv
module tb_multiplicador_seq;

    typedef struct {
        logic [31:0] prod;
        int          ciclo;
    } esperado_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iniciar = 1'b0;
    logic [15:0] mcand = 16'd0;
    logic [15:0] mplier = 16'd0;
    logic        ocupado;
    logic        pronto;
    logic [31:0] produto;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    esperado_t sb[$];

    multiplicador_seq dut (
        .Clk           (clk),
        .Rst_n         (rst_n),
        .Iniciar       (iniciar),
        .Multiplicando (mcand),
        .Multiplicador (mplier),
        .Ocupado       (ocupado),
        .Pronto        (pronto),
        .Produto       (produto)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] exigido);
        total++;
        if (atual !== exigido) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nome, atual, exigido, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever Pronto is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ocupado && pronto) begin
                chk("exclusive", 32'd1, 32'd0);
            end
            if (pronto) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pronto", 32'd1, 32'd0);
                end else begin
                    esperado_t e;
                    e = sb.pop_front();
                    chk("produto", produto, e.prod);
                    chk("latency", 32'(cyc), 32'(e.ciclo));
                    chk("ocupado_at_pronto", {31'd0, ocupado}, 32'd0);
                end
            end
        end
    end

    // Wait until the DUT is idle and all expected results were seen.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((ocupado || pronto || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    // Issue one start pulse; returns the edge count at which it was accepted.
    task automatic start(input logic [15:0] a, input logic [15:0] b, input bit push, output int k);
        mcand   = a;
        mplier  = b;
        iniciar = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        iniciar = 1'b0;
        if (push) sb.push_back('{prod: 32'(a) * 32'(b), ciclo: k + 16});
    endtask

    task automatic mult(input logic [15:0] a, input logic [15:0] b);
        int k;
        wait_idle();
        start(a, b, 1'b1, k);
        // Scramble inputs after acceptance; they must not matter.
        mcand  = 16'($urandom);
        mplier = 16'($urandom);
    endtask

    task automatic wait_cyc(input int alvo);
        int n;
        n = 0;
        while (cyc < alvo && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (cyc != alvo) chk("wait_cyc", 32'(cyc), 32'(alvo));
    endtask

    initial begin
        int k;
        logic [15:0] ra, rb;

        // Reset state and idle check
        #3;
        chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
        chk("reset_pronto", {31'd0, pronto}, 32'd0);
        chk("reset_produto", produto, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle", {30'd0, ocupado, pronto} | produto, 32'd0);
        end

        // 3x5 with Ocupado profile
        start(16'd3, 16'd5, 1'b1, k);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("ocupado_profile", {31'd0, ocupado}, 32'd1);
            chk("pronto_early", {31'd0, pronto}, 32'd0);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        chk("hold_3x5", produto, 32'h0000000F);

        // Boundary products
        mult(16'hFFFF, 16'hFFFF);
        mult(16'd8, 16'd8);
        mult(16'h1234, 16'h0000);
        mult(16'h0000, 16'hBEEF);
        mult(16'h0001, 16'hFFFF);
        wait_idle();
        chk("hold_last", produto, 32'h0000FFFF);

        // Start during CALCULA is ignored
        start(16'd3, 16'd5, 1'b1, k);
        wait_cyc(k + 5);
        start(16'd2, 16'd2, 1'b0, k);
        wait_idle();
        repeat (25) @(negedge clk);
        chk("ignored_start", produto, 32'h0000000F);

        // Iniciar held high: one product every 18 cycles
        mcand   = 16'd7;
        mplier  = 16'd9;
        iniciar = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        for (int j = 0; j < 3; j++) sb.push_back('{prod: 32'h0000003F, ciclo: k + 16 + 18 * j});
        wait_cyc(k + 53);
        iniciar = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        chk("held_final", produto, 32'h0000003F);

        // Asynchronous reset mid-calculation
        start(16'd3, 16'd5, 1'b1, k);
        wait_cyc(k + 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ocupado", {31'd0, ocupado}, 32'd0);
        chk("async_pronto", {31'd0, pronto}, 32'd0);
        chk("async_produto", produto, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_produto", produto, 32'd0);
        mult(16'd3, 16'd5);

        // Randomized operands
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) ra = 16'hFFFF;
            mult(ra, rb);
        end
        wait_idle();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
